// File: rtl/lynx_via_pkg.sv
// rtl/lynx_via_pkg.sv - flit field layout helpers for the Lynx dependency point
// Flit layout, MSB first: {ret node, ret vc, src node, dst node, vc, id[7:0], counter}.
package lynx_via_pkg;

  function automatic int cw_of(input int width, input int naw, input int vaw);
    return width - 3*naw - 2*vaw - 8;
  endfunction

  function automatic int ret_lsb(input int width, input int naw);
    return width - naw;
  endfunction

  function automatic int retvc_lsb(input int width, input int naw, input int vaw);
    return width - naw - vaw;
  endfunction

  function automatic int src_lsb(input int width, input int naw, input int vaw);
    return width - 2*naw - vaw;
  endfunction

  function automatic int dst_lsb(input int width, input int naw, input int vaw);
    return width - 3*naw - vaw;
  endfunction

  function automatic int vc_lsb(input int width, input int naw, input int vaw);
    return width - 3*naw - 2*vaw;
  endfunction

  function automatic int id_lsb(input int width, input int naw, input int vaw);
    return cw_of(width, naw, vaw);
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/via_in_fifo.sv
// rtl/via_in_fifo.sv - per-input flit FIFO with occupancy count
// Push at full and pop at empty are silently ignored.
module via_in_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CNTW-1:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/via_m_n.sv
// rtl/via_m_n.sv - NUM_IN x NUM_OUT join point for the Lynx NoC BFM layer
// Outputs fire together once every input FIFO holds a head flit (or always, under NODEP).
module via_m_n
  import lynx_via_pkg::*;
#(
  parameter int N                = 16,
  parameter int NUM_VC           = 2,
  parameter int N_ADDR_WIDTH     = $clog2(N),
  parameter int VC_ADDR_WIDTH    = $clog2(NUM_VC),
  parameter int WIDTH            = 64,
  parameter int NUM_IN           = 2,
  parameter int NUM_OUT          = 2,
  parameter int DEPTH            = 4,
  parameter int NODEP            = 0,
  parameter int RETURN_TO_SENDER = (NODEP == 0) ? 1 : 0,
  parameter int NUM_DEST         = 4,
  parameter logic [NUM_OUT*NUM_DEST*N_ADDR_WIDTH-1:0]  O_DEST = {(NUM_OUT*NUM_DEST){N_ADDR_WIDTH'(1)}},
  parameter logic [NUM_OUT*NUM_DEST*VC_ADDR_WIDTH-1:0] O_VC   = {(NUM_OUT*NUM_DEST){VC_ADDR_WIDTH'(1)}},
  parameter logic [NUM_IN*N_ADDR_WIDTH-1:0]   I_NODE = {NUM_IN{N_ADDR_WIDTH'(15)}},
  parameter logic [NUM_IN*VC_ADDR_WIDTH-1:0]  I_VC   = {NUM_IN{VC_ADDR_WIDTH'(0)}},
  parameter logic [NUM_IN*8-1:0]              I_ID   = {NUM_IN{8'd0}},
  parameter logic [NUM_OUT*N_ADDR_WIDTH-1:0]  O_NODE = {NUM_OUT{N_ADDR_WIDTH'(15)}},
  parameter logic [NUM_OUT*8-1:0]             O_ID   = {NUM_OUT{8'd0}},
  parameter int DONE_COUNT       = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             done,
  input  logic [NUM_IN*WIDTH-1:0]          i_data_in,
  input  logic [NUM_IN-1:0]                i_valid_in,
  output logic [NUM_IN-1:0]                i_ready_out,
  output logic [NUM_OUT*WIDTH-1:0]         o_data_out,
  output logic [NUM_OUT*N_ADDR_WIDTH-1:0]  o_dest_out,
  output logic [NUM_OUT*VC_ADDR_WIDTH-1:0] o_vc_out,
  output logic [NUM_OUT-1:0]               o_valid_out,
  input  logic [NUM_OUT-1:0]               o_ready_in
);

  localparam int CW        = cw_of(WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH);
  localparam int RET_LSB   = ret_lsb(WIDTH, N_ADDR_WIDTH);
  localparam int RETVC_LSB = retvc_lsb(WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH);
  localparam int CNTW      = $clog2(DEPTH + 1);
  localparam int RW        = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam logic [CW-1:0] DONE_TH = CW'(DONE_COUNT);

  logic [WIDTH-1:0]         head   [NUM_IN];
  logic [CNTW-1:0]          count  [NUM_IN];
  logic [CW-1:0]            i_cnt  [NUM_IN];
  logic [CW-1:0]            o_cnt  [NUM_OUT];
  logic [RW-1:0]            rr_ptr [NUM_OUT];
  logic [N_ADDR_WIDTH-1:0]  sel_dest [NUM_OUT];
  logic [VC_ADDR_WIDTH-1:0] sel_vc   [NUM_OUT];
  logic [NUM_IN-1:0]        empty;
  logic [NUM_IN-1:0]        full;
  logic [NUM_IN-1:0]        push;
  logic [NUM_IN-1:0]        pop;
  logic                     fire;
  logic                     unused_bits;

  assign fire = (&o_ready_in) && ((NODEP != 0) || (empty == '0));

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign i_ready_out[i] = (count[i] < CNTW'(DEPTH)) && !rst;
    assign push[i]        = i_valid_in[i] && i_ready_out[i];
    assign pop[i]         = fire && !empty[i];

    via_in_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .data  (i_data_in[i*WIDTH +: WIDTH]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i]),
      .count (count[i])
    );
  end

  // Return-to-sender follows the input-0 head; otherwise walk each output's table.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_dest[k] = '0;
      sel_vc[k]   = '0;
      if (RETURN_TO_SENDER != 0) begin
        sel_dest[k] = head[0][RET_LSB +: N_ADDR_WIDTH];
        sel_vc[k]   = head[0][RETVC_LSB +: VC_ADDR_WIDTH];
      end else begin
        sel_dest[k] = O_DEST[(k*NUM_DEST + int'(rr_ptr[k]))*N_ADDR_WIDTH +: N_ADDR_WIDTH];
        sel_vc[k]   = O_VC[(k*NUM_DEST + int'(rr_ptr[k]))*VC_ADDR_WIDTH +: VC_ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_out <= '0;
      o_dest_out  <= '0;
      o_vc_out    <= '0;
      o_data_out  <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        o_cnt[k]  <= '0;
        rr_ptr[k] <= '0;
      end
      for (int i = 0; i < NUM_IN; i++) i_cnt[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        o_valid_out[k] <= fire;
        if (fire) begin
          o_cnt[k] <= o_cnt[k] + 1'b1;
          o_dest_out[k*N_ADDR_WIDTH +: N_ADDR_WIDTH] <= sel_dest[k];
          o_vc_out[k*VC_ADDR_WIDTH +: VC_ADDR_WIDTH] <= sel_vc[k];
          o_data_out[k*WIDTH +: WIDTH] <= {I_NODE[0 +: N_ADDR_WIDTH], I_VC[0 +: VC_ADDR_WIDTH],
                                           O_NODE[k*N_ADDR_WIDTH +: N_ADDR_WIDTH],
                                           sel_dest[k], sel_vc[k], O_ID[k*8 +: 8],
                                           o_cnt[k] + 1'b1};
          rr_ptr[k] <= (rr_ptr[k] == RW'(NUM_DEST - 1)) ? '0 : rr_ptr[k] + 1'b1;
        end
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (push[i]) i_cnt[i] <= i_data_in[i*WIDTH +: CW];
      end
    end
  end

  // Under NODEP the inputs never gate progress, so only the source counters matter.
  always_comb begin
    done = 1'b1;
    if (NODEP == 0) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (i_cnt[i] <= DONE_TH) done = 1'b0;
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (o_cnt[k] <= DONE_TH) done = 1'b0;
    end
  end

  always_comb begin
    unused_bits = ^full;
    for (int i = 0; i < NUM_IN; i++) unused_bits = unused_bits ^ (^head[i]) ^ (^i_cnt[i]);
  end

endmodule
